// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Function : RV32I multi-cycle control FSM (fetch/decode/exec/mem/wb) with a
//            memory-ready handshake, wait timeout and a sticky trap state.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
   parameter int ALU_W         = 4,
   parameter int MEM_TIMEOUT   = 15,
   parameter bit SUPPORT_STORE = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      instr,
   input  logic             mem_ready,
   input  logic             branch_taken,
   output logic             mem_req,
   output logic             MemRW,
   output logic [2:0]       mem_funct3,
   output logic             ir_we,
   output logic             pc_we,
   output logic             pc_sel,
   output logic             RegWE,
   output logic [ALU_W-1:0] ALU_control,
   output logic             Imm_mux_SEL,
   output logic             WB_sel,
   output logic             trap,
   output logic [1:0]       trap_cause,
   output logic [2:0]       state
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] c_timeout = CNT_W'(MEM_TIMEOUT);

   localparam logic [3:0] c_alu_add  = 4'd0;
   localparam logic [3:0] c_alu_sub  = 4'd1;
   localparam logic [3:0] c_alu_sll  = 4'd2;
   localparam logic [3:0] c_alu_slt  = 4'd3;
   localparam logic [3:0] c_alu_sltu = 4'd4;
   localparam logic [3:0] c_alu_xor  = 4'd5;
   localparam logic [3:0] c_alu_srl  = 4'd6;
   localparam logic [3:0] c_alu_sra  = 4'd7;
   localparam logic [3:0] c_alu_or   = 4'd8;
   localparam logic [3:0] c_alu_and  = 4'd9;

   localparam logic [1:0] c_cause_illegal = 2'b01;
   localparam logic [1:0] c_cause_timeout = 2'b10;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [6:0]       r_opcode;
   logic [2:0]       r_funct3;
   logic             r_bit30;
   logic [4:0]       r_rd;
   logic [1:0]       r_trap_cause;

   logic       w_is_r;
   logic       w_is_i;
   logic       w_is_load;
   logic       w_is_store;
   logic       w_is_branch;
   logic       w_legal;
   logic [3:0] w_alu_op;
   logic       w_unused;

   // Only opcode, rd, funct3 and bit 30 steer control; the rest is datapath.
   assign w_unused = ^{instr[31], instr[29:15]};

   assign w_is_r      = (r_opcode == 7'b0110011);
   assign w_is_i      = (r_opcode == 7'b0010011);
   assign w_is_load   = (r_opcode == 7'b0000011) && (r_funct3 != 3'b011)
                        && (r_funct3[2:1] != 2'b11);
   assign w_is_store  = SUPPORT_STORE && (r_opcode == 7'b0100011)
                        && !r_funct3[2] && (r_funct3[1:0] != 2'b11);
   assign w_is_branch = (r_opcode == 7'b1100011) && (r_funct3[2:1] != 2'b01);
   assign w_legal     = w_is_r | w_is_i | w_is_load | w_is_store | w_is_branch;

   always_comb begin
      w_alu_op = c_alu_add;
      if (w_is_branch) begin
         case (r_funct3[2:1])
            2'b00:   w_alu_op = c_alu_sub;
            2'b10:   w_alu_op = c_alu_slt;
            default: w_alu_op = c_alu_sltu;
         endcase
      end else if (w_is_r || w_is_i) begin
         case (r_funct3)
            3'b000:  w_alu_op = (w_is_r && r_bit30) ? c_alu_sub : c_alu_add;
            3'b001:  w_alu_op = c_alu_sll;
            3'b010:  w_alu_op = c_alu_slt;
            3'b011:  w_alu_op = c_alu_sltu;
            3'b100:  w_alu_op = c_alu_xor;
            3'b101:  w_alu_op = r_bit30 ? c_alu_sra : c_alu_srl;
            3'b110:  w_alu_op = c_alu_or;
            default: w_alu_op = c_alu_and;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_FETCH;
         r_cnt        <= '0;
         r_opcode     <= '0;
         r_funct3     <= '0;
         r_bit30      <= 1'b0;
         r_rd         <= '0;
         r_trap_cause <= '0;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (mem_ready) begin
                  r_opcode <= instr[6:0];
                  r_funct3 <= instr[14:12];
                  r_bit30  <= instr[30];
                  r_rd     <= instr[11:7];
                  r_cnt    <= '0;
                  r_state  <= S_DECODE;
               end else if (r_cnt == c_timeout) begin
                  r_trap_cause <= c_cause_timeout;
                  r_state      <= S_TRAP;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_DECODE: begin
               if (w_legal) begin
                  r_state <= S_EXEC;
               end else begin
                  r_trap_cause <= c_cause_illegal;
                  r_state      <= S_TRAP;
               end
            end
            S_EXEC: begin
               r_cnt <= '0;
               if (w_is_r || w_is_i) begin
                  r_state <= S_WB;
               end else if (w_is_load || w_is_store) begin
                  r_state <= S_MEM;
               end else if (w_is_branch) begin
                  r_state <= S_FETCH;
               end else begin
                  r_trap_cause <= c_cause_illegal;
                  r_state      <= S_TRAP;
               end
            end
            S_MEM: begin
               if (mem_ready) begin
                  r_cnt   <= '0;
                  r_state <= w_is_load ? S_WB : S_FETCH;
               end else if (r_cnt == c_timeout) begin
                  r_trap_cause <= c_cause_timeout;
                  r_state      <= S_TRAP;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_WB: begin
               r_cnt   <= '0;
               r_state <= S_FETCH;
            end
            S_TRAP: r_state <= S_TRAP;
            default: r_state <= S_FETCH;
         endcase
      end
   end

   // Reset gates every output combinationally so nothing escapes mid-instruction.
   always_comb begin
      mem_req     = 1'b0;
      MemRW       = 1'b0;
      mem_funct3  = 3'b000;
      ir_we       = 1'b0;
      pc_we       = 1'b0;
      pc_sel      = 1'b0;
      RegWE       = 1'b0;
      ALU_control = '0;
      Imm_mux_SEL = 1'b0;
      WB_sel      = 1'b0;
      trap        = 1'b0;
      trap_cause  = 2'b00;
      state       = 3'd0;
      if (!rst) begin
         state      = r_state;
         mem_funct3 = r_funct3;
         trap_cause = r_trap_cause;
         case (r_state)
            S_FETCH: begin
               mem_req = 1'b1;
               ir_we   = mem_ready;
            end
            S_EXEC: begin
               ALU_control = ALU_W'(w_alu_op);
               Imm_mux_SEL = w_is_i | w_is_load | w_is_store;
               if (w_is_branch) begin
                  pc_we  = 1'b1;
                  pc_sel = branch_taken;
               end
            end
            S_MEM: begin
               mem_req     = 1'b1;
               MemRW       = w_is_store;
               Imm_mux_SEL = 1'b1;
               ALU_control = ALU_W'(c_alu_add);
               pc_we       = mem_ready & w_is_store;
            end
            S_WB: begin
               RegWE  = (r_rd != 5'd0);
               WB_sel = ~w_is_load;
               pc_we  = 1'b1;
            end
            S_TRAP: trap = 1'b1;
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle control FSM for the RV32I core: the sequential successor to the single-cycle combinational decoder. It sequences fetch, decode, execute, memory and write-back over several cycles with a ready-handshake to a shared instruction/data memory. It adds store and branch support, a configurable memory-wait timeout, and a sticky trap state. It drives the same datapath controls (`RegWE`, `ALU_control`, `Imm_mux_SEL`, `MemRW`, `WB_sel`) plus PC/IR enables.

## Interface
Parameters:
- `ALU_W`, 4: width of `ALU_control`; must be ≥4.
- `MEM_TIMEOUT`, 15: maximum wait cycles for `mem_ready` before trapping; must be ≥1.
- `SUPPORT_STORE`, 1: if 0, opcode 0100011 decodes as illegal.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `instr` in 32: memory read data; captured as the instruction on the fetch handshake.
- `mem_ready` in 1: memory completes the current `mem_req` this cycle.
- `branch_taken` in 1: datapath compare result, valid in EXEC.
- `mem_req` out 1: memory access request.
- `MemRW` out 1: 0 = read, 1 = write; meaningful only with `mem_req`.
- `mem_funct3` out 3: access size/sign for load/store (latched funct3).
- `ir_we` out 1: instruction-register write enable.
- `pc_we` out 1: PC write enable.
- `pc_sel` out 1: 0 = PC+4, 1 = branch target.
- `RegWE` out 1: register-file write enable.
- `ALU_control` out `ALU_W`: ALU operation.
- `Imm_mux_SEL` out 1: 1 = immediate operand B.
- `WB_sel` out 1: 0 = memory data, 1 = ALU result.
- `trap` out 1: sticky fault flag.
- `trap_cause` out 2: 01 = illegal instruction, 10 = memory timeout.
- `state` out 3: current FSM state, for debug.

## Operation
- States and encodings: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 5.
- **FETCH:** `mem_req` = 1, `MemRW` = 0. When `mem_ready` = 1:
  - `ir_we` = 1.
  - Internal decode register latches opcode, funct3, instr[30] and rd.
  - Next state is DECODE.
- **DECODE:** classify the latched instruction.
  - Legal: R (0110011); I-ALU (0010011); load (0000011) with funct3 ∈ {000,001,010,100,101}; store (0100011, `SUPPORT_STORE`) with funct3 ∈ {000,001,010}; branch (1100011) with funct3 ∉ {010,011}.
  - Legal instructions go to EXEC. Anything else goes to TRAP with cause 01.
- **EXEC, ALU encoding:** add 0, sub 1, sll 2, slt 3, sltu 4, xor 5, srl 6, sra 7, or 8, and 9.
  - R-type: bit 30 selects sub/sra.
  - I-ALU: funct3 000 is always add (bit 30 ignored); funct3 101 uses bit 30 to select srai.
  - Load/store: add with `Imm_mux_SEL` = 1.
  - Branch: beq/bne → 1; blt/bge → 3; bltu/bgeu → 4.
  - `Imm_mux_SEL` = 1 for I-ALU, load and store.
- **EXEC, next state:**
  - R or I-ALU → WB.
  - Load or store → MEM.
  - Branch: `pc_we` = 1, `pc_sel` = `branch_taken`, next state FETCH.
- **MEM:** `mem_req` = 1, `MemRW` = 1 for store and 0 for load, `ALU_control` holds add. When `mem_ready` = 1:
  - Load → WB.
  - Store → `pc_we` = 1, `pc_sel` = 0, next state FETCH.
- **WB:**
  - `RegWE` = 1 unless rd = 0.
  - `WB_sel` = 0 for a load, 1 otherwise.
  - `pc_we` = 1, `pc_sel` = 0, next state FETCH.
- **TRAP:** all enables and `mem_req` are 0; `trap` = 1; the state is held until `rst`.
- **Timeout counter:** width $clog2(`MEM_TIMEOUT`+1).
  - Clears on entry to FETCH or MEM and when `mem_ready` is seen.
  - Increments each FETCH/MEM cycle with `mem_ready` = 0.
  - When it equals `MEM_TIMEOUT` with `mem_ready` still 0, next state is TRAP with cause 10.
  - `mem_ready` in the same cycle as the limit wins: no trap.
- Outputs are Moore-style, decoded from the state register plus the latched decode register.
- `mem_funct3` is the latched funct3.
- Outside the states named above, every enable output is 0.

## Timing
- **Reset:** `rst` = 1 asynchronously sets state to FETCH, clears the counter, decode register, `trap` and `trap_cause`.
  - While `rst` is high, every output is forced to 0 (`state` = 0, `ALU_control` = 0).
  - The first `mem_req` appears in the first cycle after `rst` falls.
  - Reset mid-instruction abandons it, with no write enable issued.
- **Cycle counts with zero-wait memory** (`mem_ready` high on the first request cycle):
  - R/I-ALU: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - Each wait cycle adds 1.
- `RegWE` and `pc_we` are asserted for exactly one cycle per instruction.
- `ir_we` is asserted exactly once per instruction, in the handshake cycle.
- `mem_ready` outside FETCH/MEM is ignored.
- `instr` is sampled only in the cycle where FETCH and `mem_ready` are both 1.

## Test plan
- **add:** `add x3,x1,x2` (0x002081B3) with `mem_ready` tied 1 → states 0,1,2,4. `ALU_control` = 0 in EXEC; `RegWE` = 1 and `pc_we` = 1 in cycle 4.
- **Load with waits and sign:** `lw x5,4(x1)` with `mem_ready` low for 2 MEM cycles → MEM lasts 3 cycles, `mem_funct3` = 010, `WB_sel` = 0 in WB, 7 cycles total. Also `srai` (0x4010D093) → `ALU_control` = 7. `addi` with bit 30 set → `ALU_control` = 0.
- **Store and branch:** `sw` (0x0020A223) → `MemRW` = 1 in MEM and `RegWE` never asserted. `beq` with `branch_taken` = 1 → `pc_sel` = 1, `pc_we` = 1 in EXEC, `ALU_control` = 1.
- **Illegal instruction:** opcode 1111111, or load funct3 = 011 → TRAP, `trap_cause` = 01, and no enable asserts thereafter until `rst`.
- **Timeout boundary:** `mem_ready` held 0 in FETCH with `MEM_TIMEOUT` = 15 → TRAP after 16 FETCH cycles with cause 10. `mem_ready` arriving in the limit cycle → no trap.
- **Reset mid-operation:** assert `rst` mid-cycle during MEM of a store → all outputs 0 immediately, with no write. Release → FETCH with `mem_req` = 1 on the next cycle.
